// File: rtl/sd_spi_host_if.sv
// CPU-side port bundle of the Z-Controller SD SPI host (#57 data, #77 config/status).
interface sd_spi_host_if;
  logic       sel;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       done;

  modport slave  (input sel, wr, rd, din, output dout, busy, done);
  modport master (output sel, wr, rd, din, input dout, busy, done);
endinterface

// File: rtl/sd_spi_host.sv
// SPI mode-0 byte-exchange master for the TSConf Z-Controller SD interface.
// Optional feature macro: SD_SPI_FAST_EN enables the config-bit-2 fast SCK mode (H=1).
module sd_spi_host #(
  parameter int CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  sd_spi_host_if.slave  bus,
  output logic          sd_pwr,
  output logic          SD_CLK,
  output logic          SD_CS_N,
  output logic          SD_SI,
  input  logic          SD_SO,
  input  logic          sd_cd_n,
  input  logic          sd_wp
);

  localparam logic [7:0] HALF_LIM = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     state_q, state_d;
  logic [7:0] divcnt_q, divcnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] tx_q, tx_d, shreg_q, shreg_d, rx_q, rx_d;
  logic       fast_q, fast_d, pwr_q, pwr_d, cs_n_q, cs_n_d;
  logic       sclk_q, sclk_d, si_q, si_d, done_q, done_d;
  logic       start, cfg_wr, half_end;
  logic [7:0] half_lim;

  always_comb begin
    start    = ce && !bus.sel && (bus.wr || bus.rd) && (state_q == IDLE);
    cfg_wr   = ce && bus.sel && bus.wr;
    half_lim = fast_q ? 8'd0 : HALF_LIM;
    half_end = ce && (divcnt_q == half_lim);
  end

  always_comb begin
    state_d  = state_q;
    divcnt_d = divcnt_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    shreg_d  = shreg_q;
    rx_d     = rx_q;
    fast_d   = fast_q;
    pwr_d    = pwr_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    si_d     = si_q;
    done_d   = 1'b0;

    // Config writes land even mid-exchange; they never disturb the shifter.
    if (cfg_wr) begin
      pwr_d  = bus.din[0];
      cs_n_d = bus.din[1];
`ifdef SD_SPI_FAST_EN
      fast_d = bus.din[2];
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // wr wins over rd; a read shifts out all ones.
          tx_d     = bus.wr ? {bus.din[6:0], 1'b0} : 8'hFE;
          si_d     = bus.wr ? bus.din[7] : 1'b1;
          bitcnt_d = 3'd0;
          divcnt_d = 8'd0;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (half_end) begin
          sclk_d   = 1'b1;
          shreg_d  = {shreg_q[6:0], SD_SO};
          divcnt_d = 8'd0;
          state_d  = HIGH;
        end else if (ce) begin
          divcnt_d = divcnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (half_end) begin
          sclk_d   = 1'b0;
          divcnt_d = 8'd0;
          if (bitcnt_q == 3'd7) begin
            rx_d    = shreg_q;
            done_d  = 1'b1;
            si_d    = 1'b1;
            state_d = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            si_d     = tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
            state_d  = LOW;
          end
        end else if (ce) begin
          divcnt_d = divcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      divcnt_q <= 8'd0;
      bitcnt_q <= 3'd0;
      rx_q     <= 8'hFF;
      fast_q   <= 1'b0;
      pwr_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      si_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      divcnt_q <= divcnt_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      fast_q   <= fast_d;
      pwr_q    <= pwr_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      si_q     <= si_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_q    <= tx_d;
    shreg_q <= shreg_d;
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.dout = bus.sel ? {bus.busy, 4'b0000, fast_q, sd_wp, sd_cd_n} : rx_q;
  assign sd_pwr   = pwr_q;
  assign SD_CLK   = sclk_q;
  assign SD_CS_N  = cs_n_q;
  assign SD_SI    = si_q;

endmodule

// File: tb/tb_sd_spi_host.sv
// Directed bench for sd_spi_host: reset, write/read exchanges, busy collision,
// mid-exchange reset, clock-enable throttling and fast mode.
module tb_sd_spi_host;
  logic clk = 1'b0;
  logic reset, ce;
  logic sd_pwr, SD_CLK, SD_CS_N, SD_SI, SD_SO, sd_cd_n, sd_wp;

  sd_spi_host_if bus();

  sd_spi_host #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus),
    .sd_pwr(sd_pwr), .SD_CLK(SD_CLK), .SD_CS_N(SD_CS_N), .SD_SI(SD_SI),
    .SD_SO(SD_SO), .sd_cd_n(sd_cd_n), .sd_wp(sd_wp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave model: presents MSB first, advances on each falling SCK.
  logic [7:0] sl_byte = 8'hFF;
  int falls = 0, fall_base = 0;
  always @(negedge SD_CLK) falls++;
  always_comb begin
    int d;
    d = falls - fall_base;
    SD_SO = (d >= 0 && d < 8) ? sl_byte[7 - d] : 1'b1;
  end

  // MOSI capture at each rising SCK.
  logic [7:0] si_sh = 8'h00;
  int rises = 0;
  always @(posedge SD_CLK) begin
    si_sh <= {si_sh[6:0], SD_SI};
    rises++;
  end

  int done_cnt = 0;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] rdval;
  task automatic access(input logic s, input logic w, input logic r, input logic [7:0] d);
    bus.sel = s; bus.wr = w; bus.rd = r; bus.din = d;
    #1 rdval = bus.dout;
    @(negedge clk);
    bus.wr = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic slave_load(input logic [7:0] b);
    sl_byte = b;
    fall_base = falls;
  endtask

  task automatic run_busy(output int n, output logic dn);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    dn = bus.done;
  endtask

  int n, rb, dc, k;
  logic dn;

  initial begin
    reset = 1'b1; ce = 1'b1; sd_cd_n = 1'b0; sd_wp = 1'b1;
    bus.sel = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.din = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_cs_n", SD_CS_N, 1'b1);
    chk("rst_sclk", SD_CLK, 1'b0);
    chk("rst_si", SD_SI, 1'b1);
    chk("rst_pwr", sd_pwr, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    bus.sel = 1'b1; #1;
    chk("rst_status", bus.dout, 8'h02);
    bus.sel = 1'b0; #1;
    chk("rst_rx", bus.dout, 8'hFF);
    @(negedge clk);

    // Power on, select card, then write exchange A5 <-> 3C.
    access(1'b1, 1'b1, 1'b0, 8'h01);
    chk("cfg_pwr", sd_pwr, 1'b1);
    chk("cfg_cs_n", SD_CS_N, 1'b0);
    slave_load(8'h3C);
    rb = rises;
    access(1'b0, 1'b1, 1'b0, 8'hA5);
    run_busy(n, dn);
    chk("wr_busy_len", n, 32);
    chk("wr_done", dn, 1'b1);
    chk("wr_si_bits", si_sh, 8'hA5);
    chk("wr_sck_rises", rises - rb, 8);
    chk("wr_si_idle", SD_SI, 1'b1);
    bus.sel = 1'b0; #1;
    chk("wr_rx", bus.dout, 8'h3C);
    @(negedge clk);

    // Read-triggered exchange shifts out FF.
    slave_load(8'h81);
    rb = rises;
    access(1'b0, 1'b0, 1'b1, 8'h00);
    chk("rd_old_rx", rdval, 8'h3C);
    run_busy(n, dn);
    chk("rd_busy_len", n, 32);
    chk("rd_si_bits", si_sh, 8'hFF);
    #1;
    chk("rd_rx", bus.dout, 8'h81);
    @(negedge clk);

    // Busy collision: later write dropped, read while busy returns old rx.
    slave_load(8'h96);
    rb = rises;
    access(1'b0, 1'b1, 1'b0, 8'h11);
    repeat (3) @(negedge clk);
    access(1'b0, 1'b1, 1'b0, 8'h55);
    bus.sel = 1'b1; #1;
    chk("col_status_busy", bus.dout[7], 1'b1);
    access(1'b0, 1'b0, 1'b1, 8'h00);
    chk("col_rd_old", rdval, 8'h81);
    run_busy(n, dn);
    repeat (4) @(negedge clk);
    chk("col_sck_rises", rises - rb, 8);
    chk("col_si_bits", si_sh, 8'h11);
    chk("col_busy_after", bus.busy, 1'b0);
    bus.sel = 1'b0; #1;
    chk("col_rx", bus.dout, 8'h96);
    @(negedge clk);

    // Reset after three rising SCK edges.
    slave_load(8'hC3);
    rb = rises;
    access(1'b0, 1'b1, 1'b0, 8'h00);
    k = 0;
    while ((rises - rb) < 3 && k < 200) begin
      k++;
      @(negedge clk);
    end
    chk("mid_rises_seen", rises - rb, 3);
    dc = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_sclk", SD_CLK, 1'b0);
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_cs_n", SD_CS_N, 1'b1);
    bus.sel = 1'b0; #1;
    chk("mid_rx", bus.dout, 8'hFF);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_done", done_cnt, dc);

    // ce pulsing 1-in-3: 32 ce pulses spread over 96 clk cycles.
    access(1'b1, 1'b1, 1'b0, 8'h01);
    slave_load(8'h5A);
    access(1'b0, 1'b1, 1'b0, 8'h5A);
    n = 0; k = 1;
    while (bus.busy === 1'b1 && n < 2000) begin
      n++;
      ce = (k % 3 == 0);
      k++;
      @(negedge clk);
    end
    dn = bus.done;
    ce = 1'b1;
    chk("ce_busy_len", n, 96);
    chk("ce_done", dn, 1'b1);
    bus.sel = 1'b0; #1;
    chk("ce_rx", bus.dout, 8'h5A);
    @(negedge clk);

    // Fast-mode request: honoured only when the feature is built in.
    access(1'b1, 1'b1, 1'b0, 8'h05);
    bus.sel = 1'b1; #1;
`ifdef SD_SPI_FAST_EN
    chk("fast_status_bit2", bus.dout[2], 1'b1);
`else
    chk("fast_status_bit2", bus.dout[2], 1'b0);
`endif
    @(negedge clk);
    slave_load(8'hE7);
    rb = rises;
    access(1'b0, 1'b1, 1'b0, 8'h3B);
    run_busy(n, dn);
`ifdef SD_SPI_FAST_EN
    chk("fast_busy_len", n, 16);
`else
    chk("fast_busy_len", n, 32);
`endif
    chk("fast_si_bits", si_sh, 8'h3B);
    #1;
    chk("fast_rx", bus.dout, 8'hE7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
